// File: rtl/cover_pkg.sv
// Shared constants and state type for the toggle-coverage collector.
package cover_pkg;

  localparam int unsigned COVER_TOTAL_DEF = 8065;
  localparam int unsigned WORD_W_DEF      = 64;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  localparam int unsigned IDX_W_DEF  = $clog2(COVER_TOTAL_DEF);
  localparam int unsigned NWORDS_DEF = ceil_div(COVER_TOTAL_DEF, WORD_W_DEF);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } cover_state_e;

endpackage

// File: rtl/cover_index_fifo.sv
// Multi-push, single-pop FIFO of newly covered indices. Pushes are packed in
// ascending lane order; the caller never pushes more than free_slots entries.
module cover_index_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 13,
  parameter int unsigned LANES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [LANES-1:0]        push_valid,
  input  logic [DATA_W-1:0]       push_data [LANES],
  input  logic                    pop,
  output logic                    pop_valid,
  output logic [DATA_W-1:0]       pop_data,
  output logic [$clog2(DEPTH):0]  free_slots
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W-1:0]  wr_addr [LANES];
  logic [PTR_W:0]    n_push;
  logic              pop_eff;

  // Slot for each lane: write pointer plus the number of lower lanes pushing
  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_addr[i] = wr_ptr_q + n_push[PTR_W-1:0];
      n_push     = n_push + (PTR_W+1)'(push_valid[i]);
    end
  end

  assign pop_valid  = (count_q != '0);
  assign pop_eff    = pop && pop_valid;
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;
  // A same-cycle pop frees a slot for this cycle's pushes
  assign free_slots = (PTR_W+1)'(DEPTH) - count_q + (PTR_W+1)'(pop_eff);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_push[PTR_W-1:0];
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_eff);
      count_q  <= count_q + n_push - (PTR_W+1)'(pop_eff);
    end
  end

  // Entry storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
    end else if (!flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (push_valid[i]) mem_q[wr_addr[i]] <= push_data[i];
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage sink: records first hits in a bitmap, counts covered points
// and queues each newly covered index for the host.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEF,
  parameter int unsigned LANES       = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned IDX_W       = $clog2(COVER_TOTAL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [LANES-1:0] hit_valid,
  input  logic [IDX_W-1:0] hit_base,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W:0]   covered_count,
  output logic             overflow,
  output logic             range_err
);
  localparam int unsigned NWORDS = ceil_div(COVER_TOTAL, WORD_W);
  localparam int unsigned MAP_W  = NWORDS * WORD_W;
  localparam int unsigned CLR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W:0] TOTAL = (IDX_W+1)'(COVER_TOTAL);

  cover_state_e      state_q, state_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic [MAP_W-1:0]  bitmap_q;
  logic [IDX_W:0]    covered_q, covered_d, cov_sum;
  logic              overflow_q, overflow_d, range_err_q, range_err_d;
  logic              accept, flush, fifo_valid, pop;
  logic [IDX_W:0]    lane_idx [LANES];
  logic [LANES-1:0]  lane_new, push_valid;
  logic [IDX_W-1:0]  push_data [LANES];
  logic [FREE_W-1:0] free_slots, new_cnt;

  // Hits taken only in RUN, and not in the cycle that starts a clear
  assign accept = (state_q == RUN) && !clear_req;
  assign flush  = (state_q == RUN) && clear_req;

  // Lane lookup, FIFO slot allocation in lane order, FSM and counter next state
  always_comb begin
    new_cnt     = '0;
    overflow_d  = overflow_q;
    range_err_d = range_err_q;
    for (int i = 0; i < LANES; i++) begin
      lane_idx[i]   = {1'b0, hit_base} + (IDX_W+1)'(i);
      push_data[i]  = lane_idx[i][IDX_W-1:0];
      lane_new[i]   = 1'b0;
      push_valid[i] = 1'b0;
      if (accept && hit_valid[i]) begin
        if (lane_idx[i] >= TOTAL) begin
          range_err_d = 1'b1;
        end else if (!bitmap_q[lane_idx[i][IDX_W-1:0]]) begin
          lane_new[i] = 1'b1;
          if (new_cnt < free_slots) push_valid[i] = 1'b1;
          else                      overflow_d    = 1'b1;
          new_cnt = new_cnt + FREE_W'(1);
        end
      end
    end

    cov_sum   = covered_q + (IDX_W+1)'(new_cnt);
    covered_d = (cov_sum > TOTAL) ? TOTAL : cov_sum;
    state_d   = state_q;
    clr_d     = clr_q;

    case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d     = CLEAR;
          clr_d       = '0;
          covered_d   = '0;
          overflow_d  = 1'b0;
          range_err_d = 1'b0;
        end
      end
      CLEAR: begin
        clr_d = clr_q + CLR_W'(1);
        if (clr_q == CLR_W'(NWORDS - 1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM, sweep counter, coverage count and sticky flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      clr_q       <= '0;
      covered_q   <= '0;
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      covered_q   <= covered_d;
      overflow_q  <= overflow_d;
      range_err_q <= range_err_d;
    end
  end

  // Bitmap: one word zeroed per CLEAR cycle, first hits set in RUN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitmap_q <= '0;
    end else if (state_q == CLEAR) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (clr_q == CLR_W'(k)) bitmap_q[k*WORD_W +: WORD_W] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_new[i]) bitmap_q[lane_idx[i][IDX_W-1:0]] <= 1'b1;
      end
    end
  end

  // Each point is counted at most once, so the count never reaches saturation
  assert property (@(posedge clock) disable iff (reset) cov_sum <= TOTAL);

  cover_index_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (IDX_W),
    .LANES  (LANES)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop        (pop),
    .pop_valid  (fifo_valid),
    .pop_data   (out_index),
    .free_slots (free_slots)
  );

  assign out_valid     = fifo_valid && (state_q == RUN);
  assign pop           = out_valid && out_ready;
  assign clear_busy    = (state_q == CLEAR);
  assign covered_count = covered_q;
  assign overflow      = overflow_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector with a queue scoreboard of
// expected FIFO output and a small coverage model.
module tb_cover_toggle_collector;
  import cover_pkg::*;

  localparam int unsigned IDX_W  = IDX_W_DEF;
  localparam int unsigned NWORDS = NWORDS_DEF;
  localparam int          DEPTH  = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       hit_valid;
  logic [IDX_W-1:0] hit_base;
  logic             clear_req;
  logic             clear_busy;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0]   covered_count;
  logic             overflow;
  logic             range_err;

  int checks = 0;
  int errors = 0;

  // Model state
  int q[$];
  bit m_bm [8192];
  int m_count;
  int m_clr;
  bit m_ovf;
  bit m_rerr;

  always #5 clock = ~clock;

  cover_toggle_collector dut (
    .clock         (clock),
    .reset         (reset),
    .hit_valid     (hit_valid),
    .hit_base      (hit_base),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .covered_count (covered_count),
    .overflow      (overflow),
    .range_err     (range_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_count = 0;
    m_clr   = 0;
    m_ovf   = 1'b0;
    m_rerr  = 1'b0;
    for (int k = 0; k < 8192; k++) m_bm[k] = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_count"}, covered_count, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_range_err"}, range_err, 0);
    chk({tag, "_clear_busy"}, clear_busy, 0);
  endtask

  // One clock: compare at negedge, advance the model by this cycle's inputs
  task automatic cycle();
    int free;
    @(negedge clock);
    chk("clear_busy", clear_busy, m_clr != 0);
    chk("out_valid", out_valid, (q.size() != 0) && (m_clr == 0));
    chk("covered_count", covered_count, m_count);
    chk("overflow", overflow, m_ovf);
    chk("range_err", range_err, m_rerr);
    if (q.size() != 0 && m_clr == 0) begin
      chk("out_index", out_index, q[0]);
      if (out_ready) void'(q.pop_front());
    end
    if (m_clr != 0) begin
      m_clr--;
    end else if (clear_req) begin
      q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_rerr  = 1'b0;
      m_clr   = NWORDS;
      for (int k = 0; k < 8192; k++) m_bm[k] = 1'b0;
    end else begin
      free = DEPTH - q.size();
      for (int i = 0; i < 2; i++) begin
        if (hit_valid[i]) begin
          int idx;
          idx = int'(hit_base) + i;
          if (idx >= int'(COVER_TOTAL_DEF)) begin
            m_rerr = 1'b1;
          end else if (!m_bm[idx]) begin
            m_bm[idx] = 1'b1;
            m_count++;
            if (free > 0) begin
              q.push_back(idx);
              free--;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic hit(input logic [1:0] v, input int base);
    hit_valid = v;
    hit_base  = IDX_W'(base);
    cycle();
    hit_valid = '0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int n = 0; n < 64 && q.size() != 0; n++) cycle();
    chk({tag, "_drained"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    hit_valid = '0;
    hit_base  = '0;
    clear_req = 1'b0;
    out_ready = 1'b0;
    m_reset();
    repeat (3) @(posedge clock);
    #1;
    chk_reset_values("reset");
    reset = 1'b0;

    // First hit appears at the next cycle
    hit(2'b01, 5);
    chk("t1_valid", out_valid, 1);
    chk("t1_index", out_index, 5);
    chk("t1_count", covered_count, 1);

    // Index 5 already covered, only 6 is new
    hit(2'b11, 5);
    chk("t2_count", covered_count, 2);
    chk("t2_index_hold", out_index, 5);
    drain("t2");

    // 20 new hits into a 16-deep FIFO with the host stalled
    for (int k = 0; k < 10; k++) hit(2'b11, 100 + 2 * k);
    chk("t3_count", covered_count, 22);
    chk("t3_overflow", overflow, 1);
    chk("t3_index", out_index, 100);
    // Pop and push on a full FIFO in the same cycle
    out_ready = 1'b1;
    hit(2'b01, 200);
    chk("t3_pp_count", covered_count, 23);
    drain("t3");

    // Upper boundary: 8064 valid, 8065 out of range
    hit(2'b11, 8064);
    chk("t4_range_err", range_err, 1);
    chk("t4_count", covered_count, 24);
    chk("t4_index", out_index, 8064);
    // Base at the top of the index space: no wrap to 0
    hit(2'b11, 8191);
    chk("t4_nowrap_count", covered_count, 24);
    drain("t4");

    // Clear sweep
    for (int k = 0; k < 5; k++) hit(2'b11, 300 + 2 * k);
    chk("t5_pre_count", covered_count, 34);
    clear_req = 1'b1;
    hit(2'b01, 400);
    clear_req = 1'b0;
    hit_valid = 2'b11;
    hit_base  = IDX_W'(500);
    n = 0;
    while (clear_busy && n < 200) begin
      clear_req = (n == 50);
      cycle();
      n++;
    end
    clear_req = 1'b0;
    hit_valid = '0;
    chk("t5_busy_cycles", n, 127);
    chk("t5_count", covered_count, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_range_err", range_err, 0);
    hit(2'b01, 300);
    chk("t5_rehit_valid", out_valid, 1);
    chk("t5_rehit_index", out_index, 300);
    hit(2'b01, 400);
    chk("t5_discarded_count", covered_count, 2);
    drain("t5");

    // Asynchronous reset during a drain
    hit(2'b11, 600);
    out_ready = 1'b1;
    cycle();
    chk("t6_mid_drain_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values("rst_drain");
    m_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Asynchronous reset during a clear sweep
    hit(2'b01, 8000);
    chk("t6_pre_count", covered_count, 1);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (20) cycle();
    chk("t6_busy", clear_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values("rst_clear");
    m_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    // Word holding 8000 was not yet swept; reset must have zeroed it
    hit(2'b01, 8000);
    chk("t6_rehit_count", covered_count, 1);
    chk("t6_rehit_index", out_index, 8000);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
